ram_burst_ctrl: RTL and testbench

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_burst_ctrl_if.sv | 41 ++++
 rtl/ram_skid_fifo.sv | 58 +++++
 rtl/ram_burst_ctrl.sv | 131 +++++++++++++
 tb/tb_ram_burst_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the RAM burst controller.
// Defaults here feed the parameters of the controller and its interface.
package ram_pkg;

    localparam int RAM_AW     = 8;
    localparam int RAM_DW     = 32;
    localparam int RAM_RD_LAT = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-data and read-data handshakes of the burst controller.
// The master side issues bursts; the slave side is the controller.
interface ram_burst_ctrl_if
    import ram_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;

    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;

    logic          rdata_valid;
    logic          rdata_ready;
    logic [DW-1:0] rdata;

    logic          done;
    logic          busy;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len,
        output wdata_valid, wdata, rdata_ready,
        input  cmd_ready, wdata_ready,
        input  rdata_valid, rdata, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
        input  wdata_valid, wdata, rdata_ready,
        output cmd_ready, wdata_ready,
        output rdata_valid, rdata, done, busy
    );

endinterface

// File: rtl/ram_skid_fifo.sv
// Two-entry FIFO holding returned read words until the consumer takes them.
// Caller guarantees no push when full and no pop when empty.
module ram_skid_fifo
    import ram_pkg::*;
#(
    parameter int W = RAM_DW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wp_q, wp_d;
    logic         rp_q, rp_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (push) begin
            mem_d[wp_q] = din;
            wp_d        = ~wp_q;
        end
        if (pop) begin
            rp_d = ~rp_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rp_q];
    assign valid = (cnt_q != 2'd0);
    assign count = cnt_q;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller turning write/read bursts into single-word RAM accesses.
// Reads are windowed so in-flight plus buffered words never exceed two.
module ram_burst_ctrl
    import ram_pkg::*;
#(
    parameter int AW     = RAM_AW,
    parameter int DW     = RAM_DW,
    parameter int RD_LAT = RAM_RD_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_burst_ctrl_if.slave     bus,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_din,
    output logic                ram_rw,
    input  logic [DW-1:0]       ram_dout
);

    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          infl_q, infl_d;

    logic          wr_hs;
    logic          issue;
    logic          push;
    logic          pop;
    logic          fifo_valid;
    logic [DW-1:0] fifo_dout;
    logic [1:0]    held;
    logic [2:0]    occ;

    assign wr_hs = (state_q == S_WRITE) && bus.wdata_valid;
    assign pop   = fifo_valid && bus.rdata_ready;

    // A word popped this cycle frees its slot for a read issued this cycle.
    assign occ   = 3'(infl_q) + 3'(held) - 3'(pop);
    assign issue = (state_q == S_READ) && (occ < 3'd2);
    assign push  = (RD_LAT == 0) ? issue : infl_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        infl_d  = (RD_LAT == 0) ? 1'b0 : issue;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = bus.cmd_wr ? S_WRITE : S_READ;
                    ptr_d   = bus.cmd_addr;
                    cnt_d   = (bus.cmd_len == '0) ? LEN_MAX
                                                  : {1'b0, bus.cmd_len};
                end
            end
            S_WRITE: begin
                if (wr_hs) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - LEN_ONE;
                    if (cnt_q == LEN_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - LEN_ONE;
                    if (cnt_q == LEN_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!infl_q && held == 2'd1 && pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            infl_q  <= infl_d;
        end
    end

    ram_skid_fifo #(
        .W (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (ram_dout),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (held)
    );

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.wdata_ready = (state_q == S_WRITE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.rdata_valid = fifo_valid;
    assign bus.rdata       = fifo_dout;

    assign ram_rw   = wr_hs;
    assign ram_addr = ptr_q;
    assign ram_din  = wr_hs ? bus.wdata : '0;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural RAM, intended-contents model,
// directed and randomized bursts with stall patterns and mid-burst reset.
module tb_ram_burst_ctrl;

    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rw;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    int n_checks;
    int n_errors;

    ram_burst_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    ram_burst_ctrl #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_rw   (ram_rw),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_rw) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        check_eq({tag, "_busy"}, 32'(bus.busy), 0);
        check_eq({tag, "_done"}, 32'(bus.done), 0);
        check_eq({tag, "_wdata_ready"}, 32'(bus.wdata_ready), 0);
        check_eq({tag, "_rdata_valid"}, 32'(bus.rdata_valid), 0);
        check_eq({tag, "_rdata"}, bus.rdata, 0);
        check_eq({tag, "_ram_rw"}, 32'(ram_rw), 0);
        check_eq({tag, "_ram_addr"}, 32'(ram_addr), 0);
        check_eq({tag, "_ram_din"}, ram_din, 0);
    endtask

    // Called at 1 time unit after an edge; returns 1 unit after the accepting edge.
    task automatic issue_cmd(input bit wr, input int addr, input int len);
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = 8'(addr);
        bus.cmd_len   = 8'(len);
        #1;
        check_eq("cmd_ready", 32'(bus.cmd_ready), 1);
        check_eq("cmd_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input int addr, input logic [31:0] dq[$]);
        int len;
        int sent;
        int k;
        bit fin;
        bit v;
        len  = dq.size();
        sent = 0;
        k    = 0;
        fin  = 1'b0;
        issue_cmd(1'b1, addr, len);
        while (!fin && k < 8 * len + 50) begin
            v = (sent < len) && ($urandom_range(0, 3) != 0);
            bus.wdata_valid = v;
            bus.wdata       = (sent < len) ? dq[sent] : $urandom;
            bus.cmd_valid   = (sent < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (sent == len) begin
                check_eq("wr_done", 32'(bus.done), 1);
                check_eq("wr_end_busy", 32'(bus.busy), 0);
                check_eq("wr_end_rw", 32'(ram_rw), 0);
                fin = 1'b1;
            end else begin
                check_eq("wr_ready", 32'(bus.wdata_ready), 1);
                check_eq("wr_cmd_ready", 32'(bus.cmd_ready), 0);
                check_eq("wr_rw", 32'(ram_rw), 32'(v));
                check_eq("wr_done_early", 32'(bus.done), 0);
                if (v) begin
                    check_eq("wr_addr", 32'(ram_addr), (addr + sent) % 256);
                    check_eq("wr_din", ram_din, dq[sent]);
                    ref_mem[(addr + sent) % 256] = dq[sent];
                    sent++;
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.wdata_valid = 1'b0;
        bus.cmd_valid   = 1'b0;
        if (!fin) check_eq("wr_timeout", 0, 1);
        check_eq("wr_done_pulse", 32'(bus.done), 0);
    endtask

    // mode 0: ready always high, 1: ready 1,0,0,1 repeating, 2: random ready
    task automatic do_read(input int addr, input int len, input int mode);
        logic [31:0] exp_q[$];
        logic [31:0] held_d;
        int got;
        int k;
        int first;
        bit stalled;
        bit fin;
        bit rdy;
        got     = 0;
        k       = 0;
        first   = -1;
        stalled = 1'b0;
        fin     = 1'b0;
        held_d  = '0;
        for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(addr + i) % 256]);
        issue_cmd(1'b0, addr, len);
        while (!fin && k < 6 * len + 50) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.rdata_ready = rdy;
            bus.cmd_valid   = (got < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (got == len) begin
                check_eq("rd_done", 32'(bus.done), 1);
                check_eq("rd_end_busy", 32'(bus.busy), 0);
                fin = 1'b1;
            end else begin
                check_eq("rd_cmd_ready", 32'(bus.cmd_ready), 0);
                check_eq("rd_rw", 32'(ram_rw), 0);
                check_eq("rd_done_early", 32'(bus.done), 0);
                if (stalled) begin
                    check_eq("rd_hold_valid", 32'(bus.rdata_valid), 1);
                    check_eq("rd_hold_data", bus.rdata, held_d);
                end
                if (bus.rdata_valid && first < 0) first = k;
                if (mode == 0 && first >= 0)
                    check_eq("rd_tput", 32'(bus.rdata_valid), 1);
                if (bus.rdata_valid) begin
                    if (rdy) begin
                        check_eq("rd_data", bus.rdata, exp_q[got]);
                        got++;
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        held_d  = bus.rdata;
                    end
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.cmd_valid   = 1'b0;
        bus.rdata_ready = 1'b0;
        if (!fin) check_eq("rd_timeout", 0, 1);
        if (mode == 0) check_eq("rd_latency", 32'(first), RD_LAT + 1);
        check_eq("rd_done_pulse", 32'(bus.done), 0);
    endtask

    initial begin
        logic [31:0] dq[$];
        int a;
        int n;
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_wr      = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;

        dq = {};
        for (int i = 0; i < 4; i++) dq.push_back(32'hA0 + i);
        do_write(8'h10, dq);
        do_read(8'h10, 4, 0);

        dq = {};
        for (int i = 0; i < 256; i++) dq.push_back(i);
        do_write(0, dq);
        do_read(0, 256, 0);
        do_read(8'hFE, 3, 0);

        a  = $urandom_range(0, 255);
        dq = {};
        for (int i = 0; i < 8; i++) dq.push_back($urandom);
        do_write(a, dq);
        do_read(a, 8, 1);

        for (int t = 0; t < 6; t++) begin
            a  = $urandom_range(0, 255);
            n  = $urandom_range(1, 20);
            dq = {};
            for (int i = 0; i < n; i++) dq.push_back($urandom);
            do_write(a, dq);
            do_read(a, n, 2);
        end

        a  = $urandom_range(0, 255);
        dq = {};
        for (int i = 0; i < 6; i++) dq.push_back($urandom);
        issue_cmd(1'b1, a, 6);
        for (int i = 0; i < 2; i++) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = dq[i];
            ref_mem[(a + i) % 256] = dq[i];
            @(posedge clk);
            #1;
        end
        bus.wdata = dq[2];
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        bus.wdata_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("midrst_done", 32'(bus.done), 0);
        end
        rst_n = 1'b1;
        do_read(a, 6, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
